// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and sizing for the writeback port arbiter
package wb_pkg;

  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int WB_REQ_NUM       = 6;
  localparam int WB_PORT_NUM      = 2;

  typedef struct packed {
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [REG_DATA_WIDTH-1:0]   data;
  } wb_req_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - round-robin selection of up to PORT_NUM pending channels
module wb_rr_picker
  import wb_pkg::*;
#(
  parameter int REQ_NUM  = WB_REQ_NUM,
  parameter int PORT_NUM = WB_PORT_NUM,
  localparam int PTR_W   = ptr_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0]        mask,
  input  logic [PTR_W-1:0]          ptr,
  output logic [REQ_NUM-1:0]        grant,
  output logic [PORT_NUM*PTR_W-1:0] port_sel,
  output logic [PORT_NUM-1:0]       port_vld,
  output logic [PTR_W-1:0]          next_ptr
);

  // Scan starts at ptr and wraps; winners fill ports in scan order.
  always_comb begin
    int cnt;
    int idx;
    int last;
    grant    = '0;
    port_sel = '0;
    port_vld = '0;
    next_ptr = ptr;
    cnt      = 0;
    idx      = 0;
    last     = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = (int'(ptr) + k) % REQ_NUM;
      if (mask[idx] && cnt < PORT_NUM) begin
        grant[idx]                    = 1'b1;
        port_sel[cnt*PTR_W +: PTR_W]  = PTR_W'(idx);
        port_vld[cnt]                 = 1'b1;
        cnt                           = cnt + 1;
        last                          = idx;
      end
    end
    if (cnt != 0) next_ptr = PTR_W'((last + 1) % REQ_NUM);
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares phyf write ports among execute-unit result channels
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int REQ_NUM  = WB_REQ_NUM,
  parameter int PORT_NUM = WB_PORT_NUM,
  parameter int PHY_ID_W = PHY_REG_ID_WIDTH,
  parameter int DATA_W   = REG_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [REQ_NUM-1:0]           req_valid,
  input  logic [REQ_NUM*PHY_ID_W-1:0]  req_phy_id,
  input  logic [REQ_NUM*DATA_W-1:0]    req_data,
  output logic [REQ_NUM-1:0]           req_ready,
  output logic [PORT_NUM-1:0]          wb_phyf_we,
  output logic [PORT_NUM*PHY_ID_W-1:0] wb_phyf_id,
  output logic [PORT_NUM*DATA_W-1:0]   wb_phyf_data,
  output logic [REQ_NUM-1:0]           arb_pending
);

  localparam int PTR_W = ptr_width(REQ_NUM);

  logic [REQ_NUM-1:0]        pend;
  logic [REQ_NUM-1:0]        grant;
  logic [REQ_NUM-1:0]        accept;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          next_ptr;
  logic [PORT_NUM*PTR_W-1:0] port_sel;
  logic [PORT_NUM-1:0]       port_vld;
  logic [PHY_ID_W-1:0]       buf_id   [REQ_NUM];
  logic [DATA_W-1:0]         buf_data [REQ_NUM];

  wb_rr_picker #(
    .REQ_NUM  (REQ_NUM),
    .PORT_NUM (PORT_NUM)
  ) u_picker (
    .mask     (pend),
    .ptr      (rr_ptr),
    .grant    (grant),
    .port_sel (port_sel),
    .port_vld (port_vld),
    .next_ptr (next_ptr)
  );

  // A buffer being drained this cycle can refill on the same edge.
  assign req_ready   = ~pend | grant;
  assign accept      = req_valid & req_ready & {REQ_NUM{~flush}};
  assign arb_pending = pend;

  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (accept[i]) begin
        buf_id[i]   <= req_phy_id[i*PHY_ID_W +: PHY_ID_W];
        buf_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      rr_ptr       <= '0;
      wb_phyf_we   <= '0;
      wb_phyf_id   <= '0;
      wb_phyf_data <= '0;
    end else if (flush) begin
      pend       <= '0;
      wb_phyf_we <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (accept[i])     pend[i] <= 1'b1;
        else if (grant[i]) pend[i] <= 1'b0;
      end
      if (|grant) rr_ptr <= next_ptr;
      for (int p = 0; p < PORT_NUM; p++) begin
        wb_phyf_we[p] <= port_vld[p];
        if (port_vld[p]) begin
          wb_phyf_id[p*PHY_ID_W +: PHY_ID_W] <= buf_id[port_sel[p*PTR_W +: PTR_W]];
          wb_phyf_data[p*DATA_W +: DATA_W]   <= buf_data[port_sel[p*PTR_W +: PTR_W]];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int RN = 6;
  localparam int PN = 2;

  typedef struct {
    int      port;
    wb_req_t req;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [RN-1:0]   req_valid = '0;
  logic [RN*6-1:0] req_phy_id = '0;
  logic [RN*32-1:0] req_data = '0;
  logic [RN-1:0]   req_ready;
  logic [PN-1:0]   wb_phyf_we;
  logic [PN*6-1:0] wb_phyf_id;
  logic [PN*32-1:0] wb_phyf_data;
  logic [RN-1:0]   arb_pending;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  exp_t exp_q[$];
  int   n_items[RN];
  int   start_c[RN];

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_phy_id   (req_phy_id),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_phyf_we   (wb_phyf_we),
    .wb_phyf_id   (wb_phyf_id),
    .wb_phyf_data (wb_phyf_data),
    .arb_pending  (arb_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic wb_req_t item(input int ch, input int k, input logic [31:0] base);
    wb_req_t r;
    r.phy_id = 6'(ch * 8 + k);
    r.data   = base | 32'(ch << 8) | 32'(k);
    return r;
  endfunction

  task automatic push_exp(input int port, input int ch, input int k, input logic [31:0] base);
    exp_t e;
    e.port = port;
    e.req  = item(ch, k, base);
    exp_q.push_back(e);
  endtask

  task automatic push_raw(input int port, input logic [5:0] id, input logic [31:0] data);
    exp_t e;
    e.port        = port;
    e.req.phy_id  = id;
    e.req.data    = data;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int ch, input logic [5:0] id, input logic [31:0] data);
    req_valid[ch]         = 1'b1;
    req_phy_id[ch*6 +: 6] = id;
    req_data[ch*32 +: 32] = data;
  endtask

  task automatic set_item(input int ch, input int k, input logic [31:0] base);
    wb_req_t r;
    r = item(ch, k, base);
    set_ch(ch, r.phy_id, r.data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    flush     = 1'b0;
    rst       = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  // Each channel presents its items in order, holding payload until accepted.
  task automatic run_stream(input logic [31:0] base);
    int          idx[RN];
    int          cyc;
    bit          done;
    logic [RN-1:0] fire;
    for (int i = 0; i < RN; i++) idx[i] = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      for (int i = 0; i < RN; i++) begin
        if (cyc >= start_c[i] && idx[i] < n_items[i]) set_item(i, idx[i], base);
        else req_valid[i] = 1'b0;
      end
      #1;
      fire = req_valid & req_ready;
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < RN; i++) begin
        if (fire[i]) idx[i]++;
        if (idx[i] < n_items[i]) done = 1'b0;
      end
      cyc++;
    end
    req_valid = '0;
    check("stream_all_accepted", 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < PN; p++) begin
        if (wb_phyf_we[p]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {24'd0, 2'(p), wb_phyf_id[p*6 +: 6], wb_phyf_data[p*32 +: 32]}, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_write", {24'd0, 2'(p), wb_phyf_id[p*6 +: 6], wb_phyf_data[p*32 +: 32]},
                  {24'd0, 2'(e.port), e.req.phy_id, e.req.data});
          end
        end
      end
    end
  end

  initial begin
    #1;
    check("reset_ready", 64'(req_ready), 64'h3F);
    check("reset_we", 64'(wb_phyf_we), 64'h0);
    check("reset_id", 64'(wb_phyf_id), 64'h0);
    check("reset_data", 64'(wb_phyf_data), 64'h0);
    check("reset_pending", 64'(arb_pending), 64'h0);
    idle(2);
    rst = 1'b1;

    // Single result on channel 3
    @(negedge clk);
    push_raw(0, 6'd5, 32'hDEADBEEF);
    set_ch(3, 6'd5, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = '0;
    check("single_pend", 64'(arb_pending), 64'h08);
    check("single_we_early", 64'(wb_phyf_we), 64'h0);
    @(negedge clk);
    check("single_we", 64'(wb_phyf_we), 64'h1);
    idle(3);
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // All six channels streaming from rr_ptr=0
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < RN; ch++) push_exp(ch % 2, ch, k, 32'hA000_0000);
    for (int i = 0; i < RN; i++) begin n_items[i] = 3; start_c[i] = 0; end
    run_stream(32'hA000_0000);
    idle(8);
    check("all6_drained", 64'(exp_q.size()), 64'd0);

    // Channel 0 arrives late while 1..5 keep streaming
    do_reset();
    push_exp(0, 1, 0, 32'hB000_0000); push_exp(1, 2, 0, 32'hB000_0000);
    push_exp(0, 3, 0, 32'hB000_0000); push_exp(1, 4, 0, 32'hB000_0000);
    push_exp(0, 5, 0, 32'hB000_0000); push_exp(1, 0, 0, 32'hB000_0000);
    push_exp(0, 1, 1, 32'hB000_0000); push_exp(1, 2, 1, 32'hB000_0000);
    push_exp(0, 3, 1, 32'hB000_0000); push_exp(1, 4, 1, 32'hB000_0000);
    push_exp(0, 5, 1, 32'hB000_0000);
    n_items[0] = 1; start_c[0] = 1;
    for (int i = 1; i < RN; i++) begin n_items[i] = 2; start_c[i] = 0; end
    run_stream(32'hB000_0000);
    idle(8);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Flush with four pending plus a new arrival
    do_reset();
    @(negedge clk);
    set_item(0, 0, 32'hC000_0000); set_item(1, 0, 32'hC000_0000);
    set_item(3, 0, 32'hC000_0000); set_item(4, 0, 32'hC000_0000);
    @(negedge clk);
    req_valid = '0;
    flush     = 1'b1;
    set_item(2, 0, 32'hC000_0000);
    #1;
    check("flush_pre_pend", 64'(arb_pending), 64'h1B);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = '0;
    check("flush_pend", 64'(arb_pending), 64'h0);
    check("flush_we", 64'(wb_phyf_we), 64'h0);
    idle(4);
    // Same phy id on two channels: both write; port order shows rr_ptr kept at 0
    push_raw(0, 6'd7, 32'h1111_0000);
    push_raw(1, 6'd7, 32'h5555_0005);
    set_ch(0, 6'd7, 32'h1111_0000);
    set_ch(5, 6'd7, 32'h5555_0005);
    @(negedge clk);
    req_valid = '0;
    idle(4);
    check("flush_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while writes and pending entries are live
    do_reset();
    @(negedge clk);
    push_exp(0, 0, 0, 32'hD000_0000);
    push_exp(1, 1, 0, 32'hD000_0000);
    set_item(0, 0, 32'hD000_0000); set_item(1, 0, 32'hD000_0000);
    @(negedge clk);
    req_valid = '0;
    set_item(2, 0, 32'hD000_0000); set_item(3, 0, 32'hD000_0000);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("areset_pre_we", 64'(wb_phyf_we), 64'h3);
    #1;
    rst = 1'b0;
    #1;
    check("areset_we", 64'(wb_phyf_we), 64'h0);
    check("areset_id", 64'(wb_phyf_id), 64'h0);
    check("areset_data", 64'(wb_phyf_data), 64'h0);
    check("areset_pending", 64'(arb_pending), 64'h0);
    check("areset_ready", 64'(req_ready), 64'h3F);
    idle(2);
    rst = 1'b1;
    push_exp(0, 0, 1, 32'hE000_0000);
    push_exp(1, 5, 1, 32'hE000_0000);
    set_item(5, 1, 32'hE000_0000);
    set_item(0, 1, 32'hE000_0000);
    @(negedge clk);
    req_valid = '0;
    idle(4);
    check("areset_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
